pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register: the successor to the fixed 32-bit IF/ID latch, usable between any two stages of the pipelined CPU. It carries a PC and a payload word under a valid/ready handshake, supports flush-to-bubble, and applies backpressure. An optional skid entry registers `in_ready` so that no combinational ready path crosses the stage.

## Interface
- `DATA_W`, 32, payload width (instruction or stage bundle)
- `PC_W`, 32, PC field width
- `BUBBLE`, 0, value loaded into `out_data` on reset/flush (`DATA_W` bits)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `flush` in 1 — synchronous squash of stage contents (IF_flush successor)
- `in_valid` in 1 — upstream beat valid
- `in_ready` out 1 — stage can accept a beat this cycle
- `in_pc` in `PC_W` — upstream PC
- `in_data` in `DATA_W` — upstream payload
- `out_valid` out 1 — downstream beat valid
- `out_ready` in 1 — downstream accepts (inverse of stall)
- `out_pc` out `PC_W` — registered PC
- `out_data` out `DATA_W` — registered payload
- `occupancy` out 2 — entries held (0..2)

## Operation
- Accept = `in_valid & in_ready`; emit = `out_valid & out_ready`.
- Storage: main entry (drives `out_*`) and skid entry (present only with the macro).
- States: EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main+skid valid).
- EMPTY: accept → ONE, main←in.
- ONE: accept&emit → ONE, main←in; accept only → TWO, skid←in; emit only → EMPTY.
- TWO: `in_ready`=0; emit → ONE, main←skid; else hold.
- Priority: `rst` > `flush` > handshake.
- `rst`/`flush`: state→EMPTY, `out_pc`←0, `out_data`←`BUBBLE`, `out_valid`←0, skid cleared. A beat accepted in the same cycle is discarded.
- EMPTY reached by draining: `out_pc`/`out_data` hold their last values; `out_valid`=0.
- `out_valid` = state≠EMPTY; `occupancy` = state encoding.
- `in_ready` and all `out_*` are functions of registers only (skid build).
- No arithmetic; widths are passed through unchanged. `BUBBLE` is truncated or zero-extended to `DATA_W`.

## Timing
- Latency: an accepted beat appears on `out_*` on the next rising edge (1 cycle).
- Throughput: 1 beat/cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `out_pc`=0, `out_data`=`BUBBLE`, `occupancy`=0, `in_ready`=1.
- Backpressure: with `out_ready` low, at most 2 beats are absorbed (skid build). `in_ready` falls the edge after the second accept.
- Upstream may change `in_*` freely when `in_ready`=0; nothing is sampled.
- Simultaneous `flush` and `out_ready`: the main beat is considered emitted that cycle, and the stage is still empty afterwards.
- `rst` mid-backpressure (TWO) empties the stage in one edge; both held beats are lost.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two entries, states EMPTY/ONE/TWO as above. `in_ready` = !(state==TWO), a registered signal.
- Undefined: single entry, TWO unreachable, `occupancy` ≤ 1. `in_ready` = !`out_valid` | `out_ready`, a combinational path from `out_ready`. Latency and flush/reset behaviour are identical.

## Test plan
- Stream: `rst` 2 cycles, then PCs 0x00,0x04,0x08 with data 0x11,0x22,0x33, `out_ready`=1 → the same sequence on `out_*` one cycle later, `occupancy`=1 throughout, no gaps.
- Stall (skid): `out_ready`=0 while offering 0x04/0x22, 0x08/0x33, 0x0C/0x44 → first two accepted, `in_ready`=0, `occupancy`=2. Release → 0x22, 0x33, 0x44 emitted in order with none lost or duplicated.
- Flush with `BUBBLE`=0x13 in state TWO, `in_valid`=1 → next edge: `out_valid`=0, `out_data`=0x13, `out_pc`=0, `occupancy`=0. The concurrent beat is dropped.
- Reset mid-stream: assert `rst` during state ONE with `in_valid`=1 → next edge: all outputs at reset values, and the first beat after deassert passes with 1-cycle latency.
- Drain hold: single beat 0x20/0xAB emitted, no further input → `out_valid`=0, `out_pc`=0x20 and `out_data`=0xAB held.
- Macro undefined: repeat the stall case → only 1 beat absorbed, `in_ready` follows `out_ready` in the same cycle, `occupancy` never 2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush-to-bubble and backpressure.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry that makes in_ready a registered signal.
module pipe_stage_reg #(
    parameter int                DATA_W = 32,
    parameter int                PC_W   = 32,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              accept, emit;
    logic              load_main_in, load_main_skid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;

    assign out_valid = (state != EMPTY);
    assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = (state != TWO);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                // Without the skid entry an accept in ONE always coincides with an emit.
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush loads the bubble; draining to EMPTY leaves the last beat visible on out_pc/out_data.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_pc   <= '0;
            out_data <= BUBBLE;
        end else if (load_main_in) begin
            out_pc   <= in_pc;
            out_data <= in_data;
        end else if (load_main_skid) begin
            out_pc   <= skid_pc;
            out_data <= skid_data;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // NOTE: the skid data registers are cleared on reset/flush as well, so a stale beat can never resurface.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            skid_pc   <= '0;
            skid_data <= '0;
        end else if (state == ONE && state_nxt == TWO) begin
            skid_pc   <= in_pc;
            skid_data <= in_data;
        end
    end
`else
    assign skid_pc   = '0;
    assign skid_data = '0;
`endif

endmodule
